spectrum_peak_harmonic_analyzer: RTL and testbench

SPECTRUM_PEAK_HARMONIC_ANALYZER -- requirements
Module: spectrum_peak_harmonic_analyzer

---
 rtl/spectrum_peak_harmonic_analyzer_pkg.sv | 28 ++
 rtl/spectrum_half_ram.sv | 37 +++
 rtl/spectrum_peak_harmonic_analyzer.sv | 206 ++++++++++++++++++++
 tb/tb_spectrum_peak_harmonic_analyzer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_peak_harmonic_analyzer_pkg.sv
// Shared spectrum definitions: frame sizes, datapath widths, FSM encoding and
// the result payload carried out of the analyzer.
package spectrum_peak_harmonic_analyzer_pkg;

  localparam int unsigned FFT_POINTS_DEF  = 8192;
  localparam int unsigned HALF_POINTS_DEF = FFT_POINTS_DEF / 2;

  localparam int unsigned BIN_W  = 13;  // bin index width
  localparam int unsigned MAG_W  = 16;  // bin magnitude width
  localparam int unsigned SUM_W  = 18;  // harmonic accumulator width
  localparam int unsigned MASK_W = 4;   // one bit per harmonic order 2..5
  localparam int unsigned PROD_W = 16;  // k * peak_bin read address width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HARM    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [BIN_W-1:0]  bin;
    logic [MAG_W-1:0]  mag;
    logic [SUM_W-1:0]  sum;
    logic [MASK_W-1:0] mask;
  } result_t;

endpackage

// File: rtl/spectrum_half_ram.sv
// Capture store for the lower half of a spectrum frame.
// Simple dual-port: synchronous write port, registered read port (1-cycle
// latency). Contents are deliberately not reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, valid the cycle after raddr_i
module spectrum_half_ram
  import spectrum_peak_harmonic_analyzer_pkg::*;
#(
  parameter int unsigned DEPTH  = HALF_POINTS_DEF,
  parameter int unsigned DATA_W = MAG_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write and registered read share the clock; no reset on storage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spectrum_peak_harmonic_analyzer.sv
// Finds the largest-magnitude bin (fundamental) of a streamed FFT frame and
// sums the magnitudes of its harmonics 2..NUM_HARM from a captured copy of
// the lower half-spectrum.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : analysis enable; frames ignored while low
//   spec_data    : bin magnitude, qualified by spec_valid
//   spec_addr    : bin index, qualified by spec_valid
//   spec_valid   : single-cycle bin qualifier, no backpressure
//   peak_bin     : fundamental bin          (held until next result_valid)
//   peak_mag     : fundamental magnitude    (held until next result_valid)
//   harm_sum     : sum of in-range harmonic magnitudes
//   harm_mask    : bit i-2 set when harmonic i is below HALF_POINTS
//   result_valid : one-cycle pulse when results update
//   busy         : high whenever not IDLE
//   frame_drop   : one-cycle pulse when a frame start is ignored
module spectrum_peak_harmonic_analyzer
  import spectrum_peak_harmonic_analyzer_pkg::*;
#(
  parameter int unsigned FFT_POINTS = FFT_POINTS_DEF,
  parameter int unsigned MIN_BIN    = 2,
  parameter int unsigned NUM_HARM   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [MAG_W-1:0]  spec_data,
  input  logic [BIN_W-1:0]  spec_addr,
  input  logic              spec_valid,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [SUM_W-1:0]  harm_sum,
  output logic [MASK_W-1:0] harm_mask,
  output logic              result_valid,
  output logic              busy,
  output logic              frame_drop
);

  localparam int unsigned HALF_POINTS = FFT_POINTS / 2;
  localparam int unsigned RAM_AW      = $clog2(HALF_POINTS);
  localparam int unsigned CNT_W       = $clog2(NUM_HARM) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_HARM - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   pk_bin_q, pk_bin_d;
  logic [MAG_W-1:0]   pk_mag_q, pk_mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [MASK_W-1:0]  mask_acc_q, mask_acc_d;
  logic               in_range_q, in_range_d;
  result_t            res_q, res_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
  logic               frame_drop_q, frame_drop_d;

  logic               ram_we;
  logic [RAM_AW-1:0]  ram_waddr;
  logic [RAM_AW-1:0]  ram_raddr;
  logic [MAG_W-1:0]   ram_rdata;
  logic [PROD_W-1:0]  harm_addr;
  logic [MAG_W-1:0]   term;
  logic               frame_start;
  logic               in_half;
  logic               peak_clear;

  spectrum_half_ram #(
    .DEPTH  (HALF_POINTS),
    .DATA_W (MAG_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (spec_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Harmonic read address: (cnt+2) * fundamental, cnt counts from 0 in HARM.
  assign harm_addr   = (PROD_W'(cnt_q) + PROD_W'(2)) * PROD_W'(pk_bin_q);
  assign ram_raddr   = RAM_AW'(harm_addr);
  assign ram_waddr   = RAM_AW'(spec_addr);
  assign frame_start = spec_valid && (spec_addr == '0);
  assign in_half     = spec_addr < BIN_W'(HALF_POINTS);
  assign term        = in_range_q ? ram_rdata : '0;

  // Next-state and datapath control.
  always_comb begin
    state_d        = state_q;
    pk_bin_d       = pk_bin_q;
    pk_mag_d       = pk_mag_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    mask_acc_d     = mask_acc_q;
    in_range_d     = 1'b0;
    res_d          = res_q;
    result_valid_d = 1'b0;
    frame_drop_d   = 1'b0;
    ram_we         = 1'b0;
    peak_clear     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && frame_start) begin
          state_d    = ST_CAPTURE;
          ram_we     = 1'b1;
          peak_clear = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (spec_valid && in_half) begin
          ram_we = 1'b1;
          if (frame_start) begin
            peak_clear = 1'b1;
          end else if (spec_addr == BIN_W'(HALF_POINTS - 1)) begin
            state_d    = ST_HARM;
            cnt_d      = '0;
            acc_d      = '0;
            mask_acc_d = '0;
          end
        end
      end
      ST_HARM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A zero fundamental means no usable harmonics at all.
        in_range_d = (cnt_q < LAST_CNT) && (pk_bin_q != '0) &&
                     (harm_addr < PROD_W'(HALF_POINTS));
        // Read data for the address issued last cycle arrives now.
        if (cnt_q != '0) begin
          acc_d = acc_q + SUM_W'(term);
          if (in_range_q) begin
            mask_acc_d = mask_acc_q | (MASK_W'(1) << (cnt_q - CNT_W'(1)));
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d        = ST_DONE;
          result_valid_d = 1'b1;
          res_d.bin      = pk_bin_q;
          res_d.mag      = pk_mag_q;
          res_d.sum      = acc_d;
          res_d.mask     = mask_acc_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Running peak: strictly greater wins, so the lowest bin keeps a tie.
    if (ram_we) begin
      if (peak_clear) begin
        pk_bin_d = '0;
        pk_mag_d = '0;
      end
      if ((spec_addr >= BIN_W'(MIN_BIN)) && (spec_data > pk_mag_d)) begin
        pk_bin_d = spec_addr;
        pk_mag_d = spec_data;
      end
    end

    if (((state_q == ST_HARM) || (state_q == ST_DONE)) && frame_start) begin
      frame_drop_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pk_bin_q       <= '0;
      pk_mag_q       <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      mask_acc_q     <= '0;
      in_range_q     <= 1'b0;
      res_q          <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pk_bin_q       <= pk_bin_d;
      pk_mag_q       <= pk_mag_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      mask_acc_q     <= mask_acc_d;
      in_range_q     <= in_range_d;
      res_q          <= res_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      frame_drop_q   <= frame_drop_d;
    end
  end

  assign peak_bin     = res_q.bin;
  assign peak_mag     = res_q.mag;
  assign harm_sum     = res_q.sum;
  assign harm_mask    = res_q.mask;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign frame_drop   = frame_drop_q;

endmodule

// File: tb/tb_spectrum_peak_harmonic_analyzer.sv
// Directed bench for spectrum_peak_harmonic_analyzer (default parameters).
module tb_spectrum_peak_harmonic_analyzer;

  localparam int HALF = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] spec_data;
  logic [12:0] spec_addr;
  logic        spec_valid;
  logic [12:0] peak_bin;
  logic [15:0] peak_mag;
  logic [17:0] harm_sum;
  logic [3:0]  harm_mask;
  logic        result_valid;
  logic        busy;
  logic        frame_drop;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pres_cyc = 0;
  int rv_count = 0;
  int rv_cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  logic [15:0] frame [HALF];

  spectrum_peak_harmonic_analyzer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .spec_data    (spec_data),
    .spec_addr    (spec_addr),
    .spec_valid   (spec_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .harm_sum     (harm_sum),
    .harm_mask    (harm_mask),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_drop   (frame_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors sample mid-cycle.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin rv_count = rv_count + 1; rv_cyc = cyc; end
    if (frame_drop === 1'b1) begin fd_count = fd_count + 1; fd_cyc = cyc; end
  end

  task automatic drive_bin(input int a, input logic [15:0] d);
    @(posedge clk); #1;
    spec_valid = 1'b1; spec_addr = 13'(a); spec_data = d; pres_cyc = cyc;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin @(posedge clk); #1; spec_valid = 1'b0; end
  endtask

  task automatic send_bins(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) drive_bin(a, frame[a]);
  endtask

  task automatic clear_frame(input logic [15:0] fill);
    for (int i = 0; i < HALF; i++) frame[i] = fill;
  endtask

  task automatic load_tone();
    clear_frame(16'd10);
    frame[100] = 16'd5000; frame[200] = 16'd500; frame[300] = 16'd250;
    frame[400] = 16'd100;  frame[500] = 16'd50;
  endtask

  task automatic wait_result(input int base, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (rv_count > base) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; spec_valid = 1'b0; spec_addr = '0; spec_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({peak_bin, peak_mag, harm_sum, harm_mask, result_valid, frame_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got bin=%0d mag=%0d sum=%0d mask=%b rv=%b fd=%b exp all 0",
               peak_bin, peak_mag, harm_sum, harm_mask, result_valid, frame_drop);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1; enable = 1'b1;
    drive_idle(2);
  endtask

  task automatic test_tone();
    int base; bit got;
    base = rv_count;
    load_tone();
    send_bins(0, HALF - 1);
    drive_idle(1);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL tone_busy_harm got=%b exp=1", busy); end
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL tone_timeout got=no_result exp=result_valid"); end
    checks++;
    if (rv_cyc - pres_cyc !== 6) begin
      failures++; $display("FAIL tone_latency got=%0d exp=6", rv_cyc - pres_cyc);
    end
    checks++;
    if (peak_bin !== 13'd100) begin failures++; $display("FAIL tone_peak_bin got=%0d exp=100", peak_bin); end
    checks++;
    if (peak_mag !== 16'd5000) begin failures++; $display("FAIL tone_peak_mag got=%0d exp=5000", peak_mag); end
    checks++;
    if (harm_sum !== 18'd900) begin failures++; $display("FAIL tone_harm_sum got=%0d exp=900", harm_sum); end
    checks++;
    if (harm_mask !== 4'b1111) begin failures++; $display("FAIL tone_harm_mask got=%b exp=1111", harm_mask); end
    drive_idle(8);
    checks++;
    if (rv_count !== base + 1) begin
      failures++; $display("FAIL tone_pulse_count got=%0d exp=%0d", rv_count, base + 1);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL tone_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_range_edge();
    int base; bit got;
    base = rv_count;
    clear_frame(16'd0);
    frame[1000] = 16'd3000; frame[2000] = 16'd100; frame[3000] = 16'd100; frame[4000] = 16'd100;
    send_bins(0, HALF - 1);
    drive_idle(1);
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL range_timeout got=no_result exp=result_valid"); end
    checks++;
    if (peak_bin !== 13'd1000) begin failures++; $display("FAIL range_peak_bin got=%0d exp=1000", peak_bin); end
    checks++;
    if (harm_sum !== 18'd300) begin failures++; $display("FAIL range_harm_sum got=%0d exp=300", harm_sum); end
    checks++;
    if (harm_mask !== 4'b0111) begin failures++; $display("FAIL range_harm_mask got=%b exp=0111", harm_mask); end
    drive_idle(4);
  endtask

  task automatic test_exclusion_tie();
    int base; bit got;
    base = rv_count;
    clear_frame(16'd0);
    frame[0] = 16'd65535; frame[1] = 16'd60000; frame[50] = 16'd800; frame[60] = 16'd800;
    send_bins(0, HALF - 1);
    drive_idle(1);
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL excl_timeout got=no_result exp=result_valid"); end
    checks++;
    if (peak_bin !== 13'd50) begin failures++; $display("FAIL excl_peak_bin got=%0d exp=50", peak_bin); end
    checks++;
    if (peak_mag !== 16'd800) begin failures++; $display("FAIL excl_peak_mag got=%0d exp=800", peak_mag); end
    checks++;
    if ({harm_sum, harm_mask} !== {18'd0, 4'b1111}) begin
      failures++; $display("FAIL excl_harm got sum=%0d mask=%b exp sum=0 mask=1111", harm_sum, harm_mask);
    end
    drive_idle(4);
  endtask

  task automatic test_all_zero();
    int base; bit got;
    base = rv_count;
    clear_frame(16'd0);
    send_bins(0, HALF - 1);
    drive_idle(1);
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL zero_timeout got=no_result exp=result_valid"); end
    checks++;
    if ({peak_bin, peak_mag} !== '0) begin
      failures++; $display("FAIL zero_peak got bin=%0d mag=%0d exp 0/0", peak_bin, peak_mag);
    end
    checks++;
    if ({harm_sum, harm_mask} !== '0) begin
      failures++; $display("FAIL zero_harm got sum=%0d mask=%b exp 0/0000", harm_sum, harm_mask);
    end
    drive_idle(4);
  endtask

  task automatic test_enable_abort();
    int rv_base, fd_base;
    rv_base = rv_count; fd_base = fd_count;
    load_tone();
    send_bins(0, 500);
    @(posedge clk); #1; enable = 1'b0; spec_valid = 1'b0;
    drive_idle(2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    enable = 1'b1;
    send_bins(501, 700);
    drive_idle(20);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_no_resume got=%b exp=0", busy); end
    checks++;
    if ({rv_count, fd_count} !== {rv_base, fd_base}) begin
      failures++; $display("FAIL abort_pulses got rv=%0d fd=%0d exp rv=%0d fd=%0d",
                           rv_count, fd_count, rv_base, fd_base);
    end
  endtask

  task automatic test_restart();
    int base; bit got;
    base = rv_count;
    load_tone();
    send_bins(0, 2000);
    clear_frame(16'd0);
    frame[300] = 16'd4000;
    send_bins(0, HALF - 1);
    drive_idle(1);
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL restart_timeout got=no_result exp=result_valid"); end
    checks++;
    if (rv_cyc - pres_cyc !== 6) begin
      failures++; $display("FAIL restart_latency got=%0d exp=6", rv_cyc - pres_cyc);
    end
    checks++;
    if (peak_bin !== 13'd300) begin failures++; $display("FAIL restart_peak_bin got=%0d exp=300", peak_bin); end
    checks++;
    if (peak_mag !== 16'd4000) begin failures++; $display("FAIL restart_peak_mag got=%0d exp=4000", peak_mag); end
    drive_idle(10);
    checks++;
    if (rv_count !== base + 1) begin
      failures++; $display("FAIL restart_pulse_count got=%0d exp=%0d", rv_count, base + 1);
    end
  endtask

  task automatic test_reset_during_harm();
    int base;
    base = rv_count;
    load_tone();
    send_bins(0, HALF - 1);
    drive_idle(2);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstharm_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({peak_bin, peak_mag, harm_sum, harm_mask, result_valid, busy, frame_drop} !== '0) begin
      failures++;
      $display("FAIL rstharm_outputs got bin=%0d mag=%0d sum=%0d mask=%b rv=%b busy=%b fd=%b exp all 0",
               peak_bin, peak_mag, harm_sum, harm_mask, result_valid, busy, frame_drop);
    end
    drive_idle(2);
    rst_n = 1'b1;
    drive_idle(12);
    checks++;
    if (rv_count !== base) begin
      failures++; $display("FAIL rstharm_no_result got=%0d exp=%0d", rv_count, base);
    end
    test_tone();
  endtask

  task automatic test_frame_drop();
    int base, fd_base, last_cyc; bit got;
    base = rv_count; fd_base = fd_count;
    load_tone();
    send_bins(0, HALF - 1);
    last_cyc = pres_cyc;
    drive_idle(1);
    drive_bin(0, 16'd123);
    drive_idle(1);
    wait_result(base, got);
    checks++;
    if (!got) begin failures++; $display("FAIL drop_timeout got=no_result exp=result_valid"); end
    checks++;
    if (fd_count !== fd_base + 1) begin
      failures++; $display("FAIL drop_count got=%0d exp=%0d", fd_count, fd_base + 1);
    end
    checks++;
    if (fd_cyc !== last_cyc + 3) begin
      failures++; $display("FAIL drop_timing got=%0d exp=%0d", fd_cyc, last_cyc + 3);
    end
    checks++;
    if (rv_cyc - last_cyc !== 6) begin
      failures++; $display("FAIL drop_latency got=%0d exp=6", rv_cyc - last_cyc);
    end
    checks++;
    if ({peak_bin, peak_mag, harm_sum, harm_mask} !== {13'd100, 16'd5000, 18'd900, 4'b1111}) begin
      failures++; $display("FAIL drop_result got bin=%0d mag=%0d sum=%0d mask=%b exp 100/5000/900/1111",
                           peak_bin, peak_mag, harm_sum, harm_mask);
    end
    drive_idle(3);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got busy=%b exp=0", busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tone();
    test_range_edge();
    test_exclusion_tie();
    test_all_zero();
    test_enable_abort();
    test_restart();
    test_reset_during_harm();
    test_frame_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
